// File: rtl/tsu_pkg.sv
// Shared types and constants for the tx PTP egress stamper.
// State encoding, header byte offsets, event range, record type.
package tsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_BODY  = 2'd2,
    ST_DRAIN = 2'd3
  } tsu_state_e;

  localparam logic [5:0] OFF_ETYPE  = 6'd12;
  localparam logic [5:0] OFF_MSG    = 6'd14;
  localparam logic [5:0] OFF_SEQ    = 6'd44;
  localparam logic [5:0] VLAN_SHIFT = 6'd4;
  localparam logic [5:0] IDX_MAX    = 6'd63;

  // Event messages are 0x0..0x3; the range starts at zero.
  localparam logic [3:0] MSG_EVENT_MAX = 4'h3;

  typedef struct packed {
    logic [63:0] ts;
    logic [15:0] seq_id;
    logic [3:0]  msg_type;
  } ts_rec_t;

  function automatic logic is_event_msg(
    input logic [3:0] m
  );
    return m <= MSG_EVENT_MAX;
  endfunction

endpackage

// File: rtl/tsu_tx_ptp_stamper_if.sv
// Stream and timestamp-record bundle of the tx PTP stamper.
// slave: stamper view; master: client/MAC/consumer view.
interface tsu_tx_ptp_stamper_if;

  logic        mac_axis_tvalid;
  logic [7:0]  mac_axis_tdata;
  logic        mac_axis_tlast;
  logic        mac_axis_tready;

  logic        mac_axis_out_tvalid;
  logic [7:0]  mac_axis_out_tdata;
  logic        mac_axis_out_tlast;
  logic        mac_axis_out_tready;

  logic        ts_tvalid;
  logic        ts_tready;
  logic [63:0] ts_tdata;
  logic [15:0] ts_seq_id;
  logic [3:0]  ts_msg_type;
  logic [15:0] ts_overflow_cnt;

  modport slave (
    input  mac_axis_tvalid,
    input  mac_axis_tdata,
    input  mac_axis_tlast,
    input  mac_axis_tready,
    output mac_axis_out_tvalid,
    output mac_axis_out_tdata,
    output mac_axis_out_tlast,
    output mac_axis_out_tready,
    output ts_tvalid,
    input  ts_tready,
    output ts_tdata,
    output ts_seq_id,
    output ts_msg_type,
    output ts_overflow_cnt
  );

  modport master (
    output mac_axis_tvalid,
    output mac_axis_tdata,
    output mac_axis_tlast,
    output mac_axis_tready,
    input  mac_axis_out_tvalid,
    input  mac_axis_out_tdata,
    input  mac_axis_out_tlast,
    input  mac_axis_out_tready,
    input  ts_tvalid,
    output ts_tready,
    input  ts_tdata,
    input  ts_seq_id,
    input  ts_msg_type,
    input  ts_overflow_cnt
  );

endinterface

// File: rtl/tsu_tx_ptp_stamper_ts_slot.sv
// Single-entry valid/ready timestamp record register.
// push/push_rec in; valid/rec out, popped by pop_ready; ovf_cnt counts drops.
module tsu_ts_slot
  import tsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  ts_rec_t     push_rec,
  input  logic        pop_ready,
  output logic        valid,
  output ts_rec_t     rec,
  output logic [15:0] ovf_cnt
);

  logic        valid_q, valid_d;
  ts_rec_t     rec_q, rec_d;
  logic [15:0] ovf_q, ovf_d;
  logic        pop;

  assign pop = valid_q & pop_ready;

  // A pop in the push cycle frees the slot for the new record.
  always_comb begin
    valid_d = valid_q;
    rec_d   = rec_q;
    ovf_d   = ovf_q;
    if (push) begin
      if (!valid_q || pop) begin
        valid_d = 1'b1;
        rec_d   = push_rec;
      end else if (ovf_q != 16'hFFFF) begin
        ovf_d = ovf_q + 16'd1;
      end
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
      ovf_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid   = valid_q;
  assign rec     = rec_q;
  assign ovf_cnt = ovf_q;

endmodule

// File: rtl/tsu_tx_ptp_stamper.sv
// Tx PTP egress stamper: zero-latency stream tap that stamps event frames.
// Ports: aclk/resetn, rtc_timer_in, bus (stream in/out, ts record out).
module tsu_tx_ptp_stamper
  import tsu_pkg::*;
#(
  parameter logic [15:0] PTP_ETHERTYPE = 16'h88F7,
  parameter logic [15:0] VLAN_TPID     = 16'h8100,
  parameter logic [63:0] TS_ADJ        = 64'd0
) (
  input  logic                       mac_axis_aclk,
  input  logic                       mac_axis_resetn,
  input  logic [63:0]                rtc_timer_in,
  tsu_tx_ptp_stamper_if.slave        bus
);

  tsu_state_e  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [63:0] ts_cap_q, ts_cap_d;
  logic [15:0] etype_q, etype_d;
  logic        vlan_q, vlan_d;
  logic [3:0]  msg_q, msg_d;
  logic [7:0]  seq_hi_q, seq_hi_d;
  logic        fresh_q;

  logic        hs;
  logic        tlast;
  logic [7:0]  tdata;
  logic [5:0]  off;
  logic        at_et_hi, at_et_lo;
  logic        at_msg, at_seq_hi, at_seq_lo;
  logic [15:0] etype_now;
  logic        tag_seen, non_ptp;
  logic        push;
  ts_rec_t     push_rec, slot_rec;
  logic        slot_valid;
  logic [15:0] slot_ovf;

  assign bus.mac_axis_out_tvalid = bus.mac_axis_tvalid;
  assign bus.mac_axis_out_tdata  = bus.mac_axis_tdata;
  assign bus.mac_axis_out_tlast  = bus.mac_axis_tlast;
  assign bus.mac_axis_out_tready = bus.mac_axis_tready;

  assign hs    = bus.mac_axis_tvalid & bus.mac_axis_tready;
  assign tlast = bus.mac_axis_tlast;
  assign tdata = bus.mac_axis_tdata;

  assign off       = vlan_q ? VLAN_SHIFT : 6'd0;
  assign at_et_hi  = idx_q == OFF_ETYPE + off;
  assign at_et_lo  = idx_q == OFF_ETYPE + off + 6'd1;
  assign at_msg    = idx_q == OFF_MSG + off;
  assign at_seq_hi = idx_q == OFF_SEQ + off;
  assign at_seq_lo = idx_q == OFF_SEQ + off + 6'd1;

  // Ethertype is resolved on its low byte; a tag defers it 4 bytes.
  assign etype_now = {etype_q[15:8], tdata};
  assign tag_seen  = at_et_lo & ~vlan_q
                   & (etype_now == VLAN_TPID);
  assign non_ptp   = at_et_lo & ~tag_seen
                   & (etype_now != PTP_ETHERTYPE);

  always_ff @(posedge mac_axis_aclk or negedge mac_axis_resetn) begin
    if (!mac_axis_resetn) begin
      state_q <= ST_IDLE;
      fresh_q <= 1'b1;
    end else begin
      state_q <= state_d;
      fresh_q <= 1'b0;
    end
  end

  // Traffic seen on the first clock after reset may be mid-frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fresh_q && bus.mac_axis_tvalid) begin
          if (!(hs && tlast)) state_d = ST_DRAIN;
        end else if (hs && !tlast) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (hs) begin
          if (tlast) state_d = ST_IDLE;
          else if (at_seq_lo || non_ptp) state_d = ST_BODY;
        end
      end
      ST_BODY, ST_DRAIN: begin
        if (hs && tlast) state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    ts_cap_d = ts_cap_q;
    etype_d  = etype_q;
    vlan_d   = vlan_q;
    msg_d    = msg_q;
    seq_hi_d = seq_hi_q;
    push     = 1'b0;
    if (hs) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fresh_q) begin
            idx_d    = 6'd1;
            ts_cap_d = rtc_timer_in + TS_ADJ;
            etype_d  = '0;
            vlan_d   = 1'b0;
            msg_d    = '0;
            seq_hi_d = '0;
          end
        end
        ST_HDR: begin
          if (idx_q != IDX_MAX) idx_d = idx_q + 6'd1;
          if (at_et_hi) etype_d[15:8] = tdata;
          if (at_et_lo) begin
            etype_d[7:0] = tdata;
            vlan_d       = vlan_q | tag_seen;
          end
          if (at_msg)    msg_d    = tdata[3:0];
          if (at_seq_hi) seq_hi_d = tdata;
          push = at_seq_lo
               & (etype_q == PTP_ETHERTYPE)
               & is_event_msg(msg_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge mac_axis_aclk or negedge mac_axis_resetn) begin
    if (!mac_axis_resetn) begin
      idx_q    <= '0;
      ts_cap_q <= '0;
      etype_q  <= '0;
      vlan_q   <= 1'b0;
      msg_q    <= '0;
      seq_hi_q <= '0;
    end else begin
      idx_q    <= idx_d;
      ts_cap_q <= ts_cap_d;
      etype_q  <= etype_d;
      vlan_q   <= vlan_d;
      msg_q    <= msg_d;
      seq_hi_q <= seq_hi_d;
    end
  end

  assign push_rec.ts       = ts_cap_q;
  assign push_rec.seq_id   = {seq_hi_q, tdata};
  assign push_rec.msg_type = msg_q;

  tsu_ts_slot u_slot (
    .clk       (mac_axis_aclk),
    .rst_n     (mac_axis_resetn),
    .push      (push),
    .push_rec  (push_rec),
    .pop_ready (bus.ts_tready),
    .valid     (slot_valid),
    .rec       (slot_rec),
    .ovf_cnt   (slot_ovf)
  );

  assign bus.ts_tvalid       = slot_valid;
  assign bus.ts_tdata        = slot_rec.ts;
  assign bus.ts_seq_id       = slot_rec.seq_id;
  assign bus.ts_msg_type     = slot_rec.msg_type;
  assign bus.ts_overflow_cnt = slot_ovf;

endmodule

// File: tb/tb_tsu_tx_ptp_stamper.sv
// Scoreboard bench for tsu_tx_ptp_stamper with directed frames.
// Driver queues expected bytes/records; negedge monitors pop and compare.
module tb_tsu_tx_ptp_stamper;
  import tsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] rtc = '0;

  always #5 clk = ~clk;

  tsu_tx_ptp_stamper_if bus();

  tsu_tx_ptp_stamper #(
    .PTP_ETHERTYPE (16'h88F7),
    .VLAN_TPID     (16'h8100),
    .TS_ADJ        (64'd8)
  ) dut (
    .mac_axis_aclk   (clk),
    .mac_axis_resetn (rst_n),
    .rtc_timer_in    (rtc),
    .bus             (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] frm[$];
  logic [8:0] exp_bytes[$];
  ts_rec_t    exp_recs[$];

  function automatic void chk(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void put(input int idx, input logic [7:0] v);
    if (idx < frm.size()) frm[idx] = v;
  endfunction

  task automatic build(
    input bit          vlan,
    input logic [15:0] et,
    input logic [3:0]  msg,
    input logic [15:0] seq,
    input int          len
  );
    int off;
    off = vlan ? 4 : 0;
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'(i * 7 + 3));
    if (vlan) begin
      put(12, 8'h81);
      put(13, 8'h00);
      put(14, 8'h00);
      put(15, 8'h05);
    end
    put(12 + off, et[15:8]);
    put(13 + off, et[7:0]);
    put(14 + off, {4'hA, msg});
    put(44 + off, seq[15:8]);
    put(45 + off, seq[7:0]);
  endtask

  function automatic void expect_rec(
    input logic [63:0] ts,
    input logic [15:0] seq,
    input logic [3:0]  msg
  );
    ts_rec_t r;
    r.ts       = ts;
    r.seq_id   = seq;
    r.msg_type = msg;
    exp_recs.push_back(r);
  endfunction

  // Called and returns at posedge+2; rtc = base + cycles since frame start.
  task automatic send(
    input logic [63:0] base,
    input bit          toggle,
    input int          pulse
  );
    int i;
    int cyc;
    int n;
    n = frm.size();
    i = 0;
    cyc = 0;
    for (int k = 0; k < n; k++)
      exp_bytes.push_back({1'(k == n - 1), frm[k]});
    while (i < n) begin
      bus.mac_axis_tvalid = 1'b1;
      bus.mac_axis_tdata  = frm[i];
      bus.mac_axis_tlast  = 1'(i == n - 1);
      bus.mac_axis_tready = toggle ? 1'(cyc % 3 != 1) : 1'b1;
      if (pulse >= 0) bus.ts_tready = 1'(i == pulse);
      rtc = base + 64'(cyc);
      @(posedge clk);
      #2;
      if (bus.mac_axis_tready) i++;
      cyc++;
    end
    bus.mac_axis_tvalid = 1'b0;
    bus.mac_axis_tlast  = 1'b0;
    bus.mac_axis_tready = 1'b1;
    if (pulse >= 0) bus.ts_tready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", 128'(bus.ts_tvalid), 128'd0);
    chk("rst_tdata", 128'(bus.ts_tdata), 128'd0);
    chk("rst_seq", 128'(bus.ts_seq_id), 128'd0);
    chk("rst_msg", 128'(bus.ts_msg_type), 128'd0);
    chk("rst_ovf", 128'(bus.ts_overflow_cnt), 128'd0);
    idle(2);
  endtask

  always @(negedge clk) begin
    logic [8:0] b;
    if (bus.mac_axis_out_tvalid && bus.mac_axis_tready) begin
      if (exp_bytes.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra: got %0h expected none",
                 bus.mac_axis_out_tdata);
      end else begin
        b = exp_bytes.pop_front();
        chk("stream",
            {bus.mac_axis_out_tready, bus.mac_axis_out_tlast,
             bus.mac_axis_out_tdata},
            {1'b1, b});
      end
    end
  end

  always @(negedge clk) begin
    ts_rec_t r;
    if (rst_n && bus.ts_tvalid && bus.ts_tready) begin
      if (exp_recs.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rec_extra: got seq %0h expected none",
                 bus.ts_seq_id);
      end else begin
        r = exp_recs.pop_front();
        chk("ts_rec",
            {bus.ts_tdata, bus.ts_seq_id, bus.ts_msg_type},
            {r.ts, r.seq_id, r.msg_type});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.mac_axis_tvalid = 1'b0;
    bus.mac_axis_tdata  = '0;
    bus.mac_axis_tlast  = 1'b0;
    bus.mac_axis_tready = 1'b1;
    bus.ts_tready       = 1'b1;

    @(posedge clk);
    #2;
    do_reset();
    rst_n = 1'b1;
    idle(2);

    // Untagged Sync ending on the sequenceId byte.
    build(1'b0, 16'h88F7, 4'h0, 16'h1234, 46);
    expect_rec(64'd1008, 16'h1234, 4'h0);
    send(64'd1000, 1'b0, -1);
    chk("sync_valid_lat", 128'(bus.ts_tvalid), 128'd1);
    idle(2);

    // Timestamp adjust wraps modulo 2^64.
    build(1'b0, 16'h88F7, 4'h0, 16'h0042, 60);
    expect_rec(64'd4, 16'h0042, 4'h0);
    send(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, -1);
    idle(2);

    // VLAN Delay_Req with a stalling MAC.
    build(1'b1, 16'h88F7, 4'h1, 16'hBEEF, 64);
    expect_rec(64'd5008, 16'hBEEF, 4'h1);
    send(64'd5000, 1'b1, -1);
    idle(2);

    // IPv4 and Announce: no record.
    build(1'b0, 16'h0800, 4'h0, 16'h5555, 60);
    send(64'd6000, 1'b0, -1);
    build(1'b0, 16'h88F7, 4'hB, 16'h6666, 60);
    send(64'd6500, 1'b0, -1);
    idle(3);
    chk("ovf_non_event", 128'(bus.ts_overflow_cnt), 128'd0);

    // Runt then Sync.
    build(1'b0, 16'h88F7, 4'h0, 16'h7777, 40);
    send(64'd6800, 1'b0, -1);
    build(1'b0, 16'h88F7, 4'h0, 16'h0101, 60);
    expect_rec(64'd7008, 16'h0101, 4'h0);
    send(64'd7000, 1'b0, -1);
    idle(3);

    // Back-to-back Syncs with consumer stalled.
    bus.ts_tready = 1'b0;
    build(1'b0, 16'h88F7, 4'h0, 16'h0A0A, 60);
    expect_rec(64'd2008, 16'h0A0A, 4'h0);
    send(64'd2000, 1'b0, -1);
    build(1'b0, 16'h88F7, 4'h0, 16'h0B0B, 60);
    send(64'd3000, 1'b0, -1);
    idle(1);
    chk("ovf_drop", 128'(bus.ts_overflow_cnt), 128'd1);
    chk("held_seq", 128'(bus.ts_seq_id), 128'h0A0A);
    bus.ts_tready = 1'b1;
    idle(4);

    do_reset();
    rst_n = 1'b1;
    idle(2);

    // Pop on the push cycle loads the second record.
    bus.ts_tready = 1'b0;
    build(1'b0, 16'h88F7, 4'h0, 16'h0C0C, 60);
    expect_rec(64'd2108, 16'h0C0C, 4'h0);
    send(64'd2100, 1'b0, -1);
    build(1'b0, 16'h88F7, 4'h0, 16'h0D0D, 60);
    expect_rec(64'd3108, 16'h0D0D, 4'h0);
    send(64'd3100, 1'b0, 45);
    idle(1);
    chk("ovf_pulse", 128'(bus.ts_overflow_cnt), 128'd0);
    bus.ts_tready = 1'b1;
    idle(4);

    // Reset released with traffic already flowing.
    do_reset();
    build(1'b0, 16'h88F7, 4'h0, 16'h0E0E, 60);
    rst_n = 1'b1;
    send(64'd8000, 1'b0, -1);
    build(1'b0, 16'h88F7, 4'h0, 16'h0F0F, 60);
    expect_rec(64'd9008, 16'h0F0F, 4'h0);
    send(64'd9000, 1'b0, -1);
    idle(5);

    chk("recs_left", 128'(exp_recs.size()), 128'd0);
    chk("bytes_left", 128'(exp_bytes.size()), 128'd0);
    chk("ovf_final", 128'(bus.ts_overflow_cnt), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tsu_tx_ptp_stamper.md
TSU_TX_PTP_STAMPER -- requirements
Module: tsu_tx_ptp_stamper

Interface
REQ-001 The block SHALL have exactly one clock and one reset; the reset is asynchronous and active-low.
REQ-002 Parameter PTP_ETHERTYPE, default 16'h88F7: Ethertype that identifies a PTP frame.
REQ-003 Parameter VLAN_TPID, default 16'h8100: tag that shifts the Ethertype and PTP offsets by 4 bytes.
REQ-004 Parameter TS_ADJ, default 64'd0: constant added to each captured timestamp to compensate for MAC/PHY pipeline delay.
REQ-005 mac_axis_aclk  in  1  MAC transmit clock; all logic is on its rising edge.
REQ-006 mac_axis_resetn  in  1  asynchronous active-low reset.
REQ-007 rtc_timer_in  in  64  RTC time in ns, already synchronous to mac_axis_aclk.
REQ-008 mac_axis_tvalid, mac_axis_tdata[7:0], mac_axis_tlast  in  1/8/1  frame byte stream from the tx client FIFO.
REQ-009 mac_axis_tready  in  1  ready from the MAC core.
REQ-010 mac_axis_out_tvalid, mac_axis_out_tdata[7:0], mac_axis_out_tlast  out  1/8/1  stream to the MAC core.
REQ-011 mac_axis_out_tready  out  1  ready back to the FIFO.
REQ-012 ts_tvalid  out  1  timestamp record valid.
REQ-013 ts_tready  in  1  timestamp record consumed.
REQ-014 ts_tdata  out  64  egress timestamp, in ns.
REQ-015 ts_seq_id  out  16  PTP sequenceId.
REQ-016 ts_msg_type  out  4  PTP messageType.
REQ-017 ts_overflow_cnt  out  16  count of dropped records; saturates at 16'hFFFF.

Function
REQ-018 The stream path SHALL be combinational pass-through with zero latency; the block never alters data or stalls it. A handshake (hs) is tvalid & tready on this path.
REQ-019 The FSM SHALL have four states: IDLE, HDR, BODY, DRAIN.
REQ-020 IDLE: on hs, capture ts_cap = rtc_timer_in + TS_ADJ (mod 2^64), set the byte index to 1, and go to HDR. If that byte also has tlast, stay in IDLE.
REQ-021 HDR: increment the 6-bit byte index on each hs.
- Latch the Ethertype from bytes 12-13.
- If it equals VLAN_TPID, set the vlan flag and take the Ethertype from bytes 16-17.
- Take the msgType from the low nibble of byte 14 (byte 18 with VLAN).
- Take the sequenceId from bytes 44-45 (48-49 with VLAN), big-endian.
REQ-022 A frame is an event frame when its Ethertype equals PTP_ETHERTYPE and msgType is 0x0-0x3.
REQ-023 On hs of the last sequenceId byte:
- Event frame: push the record {ts_cap, seq_id, msg_type}.
- Any frame: go to BODY, or to IDLE if that byte has tlast.
REQ-024 A frame that is not PTP SHALL go to BODY as soon as its Ethertype is resolved.
REQ-025 BODY: on hs with tlast, go to IDLE.
REQ-026 HDR: hs with tlast before the sequenceId is complete (runt frame) goes to IDLE and pushes no record.
REQ-027 ts_tvalid SHALL assert on the cycle after the push hs. The record holds stable until ts_tvalid & ts_tready.
REQ-028 Push while a record is still pending and not popped: keep the old record, drop the new one, and increment ts_overflow_cnt (saturating).
REQ-029 Pop and push on the same cycle: the new record is loaded with no overflow.
REQ-030 The byte index SHALL saturate at 63.

Reset
REQ-031 During reset, all of the following SHALL be 0: ts_tvalid, ts_tdata, ts_seq_id, ts_msg_type, ts_overflow_cnt, FSM state variable, byte index.
REQ-032 After reset, the FSM SHALL be in IDLE.
REQ-033 First clock after reset deassertion with mac_axis_tvalid=1: enter DRAIN, because the stream may be mid-frame.
REQ-034 DRAIN: on hs with tlast, go to IDLE; no records are produced in DRAIN.
REQ-035 Reset asserted mid-frame SHALL discard any partial record.

Structure
REQ-036 Package tsu_pkg SHALL hold the FSM state encoding, byte-offset constants (12, 14, 44, VLAN shift 4), and the event msgType range.
REQ-037 The one natural sub-module SHALL be tsu_ts_slot: a single-entry valid/ready record register with the overflow counter.

Verification
REQ-038 Untagged Sync (Ethertype 88F7, msgType 0x0, seqId 0x1234), rtc=1000 at the first hs, TS_ADJ=8 -> one record {1008, 0x1234, 0x0}, valid 1 cycle after byte 45 hs.
REQ-039 VLAN-tagged Delay_Req (msgType 0x1, seqId 0xBEEF) with mac_axis_tready toggling -> record seqId 0xBEEF, ts_tdata = rtc value at first hs + TS_ADJ, output stream byte-identical to input.
REQ-040 IPv4 frame (0800) and a PTP Announce (msgType 0xB) -> no record; ts_overflow_cnt stays 0.
REQ-041 Two back-to-back Sync frames with ts_tready=0 -> first record held, ts_overflow_cnt=1. Same test with ts_tready pulsed on the push cycle -> second record loaded, count 0.
REQ-042 40-byte PTP runt, then a valid Sync -> only the Sync record is produced.
REQ-043 Reset released mid-frame with tvalid=1 -> DRAIN until tlast, no record; next Sync stamps correctly.
